// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM states, arbitration winner encoding and word geometry
package ram_port_arbiter_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {IDLE, H_COLLECT, H_WREQ, H_RREQ, H_RWAIT, H_EMIT} state_t;
    typedef enum logic {WIN_CPU = 1'b0, WIN_HOST = 1'b1} winner_t;
endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, CPU vs host, favouring whoever did not win last
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic host_req,
    output logic cpu_gnt,
    output logic host_gnt
);
    winner_t last_win_q, last_win_d;
    always_comb begin
        cpu_gnt    = cpu_req & (~host_req | (last_win_q == WIN_HOST));
        host_gnt   = host_req & ~cpu_gnt;
        last_win_d = cpu_gnt ? WIN_CPU : host_gnt ? WIN_HOST : last_win_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_win_q <= WIN_HOST;
        else     last_win_q <= last_win_d;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the program RAM between the CPU port and a byte-serial host port
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_cmd_valid,
    input  logic              host_cmd_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_bvalid,
    input  logic [7:0]        host_byte,
    output logic              host_ovalid,
    output logic [7:0]        host_obyte,
    output logic              host_busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);
    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                ovalid_d, busy_d, rvalid_d;
    logic [7:0]          obyte_d;
    logic                host_req, host_gnt;
    // Requests are masked during reset so every combinational RAM-side output reads 0
    assign host_req = ~rst & ((state_q == H_WREQ) | (state_q == H_RREQ));
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req & ~rst),
        .host_req(host_req),
        .cpu_gnt (cpu_gnt),
        .host_gnt(host_gnt)
    );
    assign ram_we    = host_gnt ? (state_q == H_WREQ) : (cpu_gnt & cpu_we);
    assign ram_addr  = rst ? '0 : host_gnt ? addr_q : cpu_addr;
    assign ram_wdata = rst ? '0 : host_gnt ? word_q : cpu_wdata;
    assign cpu_rdata = ram_rdata;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (host_cmd_valid) begin
                addr_d  = host_addr;
                idx_d   = 2'd0;
                state_d = host_cmd_wr ? H_COLLECT : H_RREQ;
            end
            H_COLLECT: if (host_bvalid) begin
                word_d[{idx_q, 3'b000} +: 8] = host_byte;
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == LAST_IDX) ? H_WREQ : H_COLLECT;
            end
            H_WREQ:  state_d = host_gnt ? IDLE : H_WREQ;
            H_RREQ:  state_d = host_gnt ? H_RWAIT : H_RREQ;
            H_RWAIT: begin
                word_d  = ram_rdata;
                idx_d   = 2'd0;
                state_d = H_EMIT;
            end
            H_EMIT: begin
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == LAST_IDX) ? IDLE : H_EMIT;
            end
            default: state_d = IDLE;
        endcase
        // Output byte is looked ahead from next-state so host_ovalid/host_obyte are registered
        ovalid_d = (state_d == H_EMIT);
        obyte_d  = ovalid_d ? word_d[{idx_d, 3'b000} +: 8] : 8'h00;
        busy_d   = (state_d != IDLE);
        rvalid_d = cpu_gnt & ~cpu_we;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            addr_q      <= '0;
            word_q      <= '0;
            host_ovalid <= 1'b0;
            host_obyte  <= 8'h00;
            host_busy   <= 1'b0;
            cpu_rvalid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            host_ovalid <= ovalid_d;
            host_obyte  <= obyte_d;
            host_busy   <= busy_d;
            cpu_rvalid  <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table-driven and sequence checks of ram_port_arbiter against a RAM model
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        host_cmd_valid = 1'b0, host_cmd_wr = 1'b0;
    logic [4:0]  host_addr = '0;
    logic        host_bvalid = 1'b0;
    logic [7:0]  host_byte = '0;
    logic        host_ovalid, host_busy;
    logic [7:0]  host_obyte;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] mem [32];
    int total = 0, bad = 0, we_cnt = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_cmd_valid(host_cmd_valid), .host_cmd_wr(host_cmd_wr), .host_addr(host_addr),
        .host_bvalid(host_bvalid), .host_byte(host_byte),
        .host_ovalid(host_ovalid), .host_obyte(host_obyte), .host_busy(host_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) if (ram_we) we_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [4:0] a, input logic [31:0] wd, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        #1;
        chk("cpu_gnt", cpu_gnt, 1);
        chk("cpu_ram_we", ram_we, we);
        chk("cpu_ram_addr", ram_addr, a);
        tick();
        cpu_req = 1'b0;
        chk("cpu_rvalid", cpu_rvalid, !we);
        if (!we) chk("cpu_rdata", cpu_rdata, exp);
    endtask

    task automatic host_cmd(input logic wr, input logic [4:0] a);
        host_cmd_valid = 1'b1; host_cmd_wr = wr; host_addr = a;
        tick();
        host_cmd_valid = 1'b0;
        chk("host_busy_accept", host_busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        host_bvalid = 1'b1; host_byte = b;
        tick();
        host_bvalid = 1'b0;
    endtask

    task automatic host_read_chk(input logic [4:0] a, input logic [31:0] exp);
        int n = 0;
        host_cmd(1'b0, a);
        while (!host_ovalid && n < 10) begin
            tick();
            n++;
        end
        chk("rd_latency", n, 2);
        for (int i = 0; i < 4; i++) begin
            chk("rd_ovalid", host_ovalid, 1);
            chk("rd_obyte", host_obyte, exp[8*i +: 8]);
            tick();
        end
        chk("rd_ovalid_end", host_ovalid, 0);
        chk("rd_busy_end", host_busy, 0);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int w0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd31, 32'h12345678, 32'h0};
        vecs[3] = '{1'b1, 5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[4] = '{1'b0, 5'd31, 32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        32'hA5A5A5A5};

        // reset state, with a CPU request present that must not leak to the RAM port
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'hFFFFFFFF;
        tick(); tick();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_host_ovalid", host_ovalid, 0);
        chk("rst_host_obyte", host_obyte, 0);
        chk("rst_host_busy", host_busy, 0);
        cpu_req = 1'b0;
        rst = 1'b0;
        tick();

        // 1: CPU-only table
        for (int i = 0; i < 6; i++) cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // 2: host write of 0x44332211 to addr 7
        w0 = we_cnt;
        host_cmd(1'b1, 5'd7);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("hw_no_early_we", we_cnt, w0);
        send_byte(8'h44);
        chk("hw_ram_we", ram_we, 1);
        chk("hw_ram_addr", ram_addr, 7);
        chk("hw_ram_wdata", ram_wdata, 32'h44332211);
        tick();
        chk("hw_busy_fall", host_busy, 0);
        chk("hw_we_after", ram_we, 0);
        chk("hw_we_count", we_cnt, w0 + 1);

        // 3: host read of addr 7
        host_read_chk(5'd7, 32'h44332211);

        // 4: tie right after reset -> CPU first, then host
        rst = 1'b1; tick(); rst = 1'b0; tick();
        host_cmd(1'b1, 5'd9);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd10; cpu_wdata = 32'hAAAA0000;
        #1;
        chk("tie1_cpu_gnt", cpu_gnt, 1);
        chk("tie1_ram_addr", ram_addr, 10);
        chk("tie1_ram_wdata", ram_wdata, 32'hAAAA0000);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("tie1_host_we", ram_we, 1);
        chk("tie1_host_addr", ram_addr, 9);
        chk("tie1_host_wdata", ram_wdata, 32'h01020304);
        tick();
        chk("tie1_busy", host_busy, 0);
        // CPU-only grant makes CPU the last winner, so the next tie goes to the host
        cpu_op(1'b0, 5'd10, 32'h0, 32'hAAAA0000);
        host_cmd(1'b1, 5'd11);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
        #1;
        chk("tie2_cpu_gnt", cpu_gnt, 0);
        chk("tie2_host_we", ram_we, 1);
        chk("tie2_host_addr", ram_addr, 11);
        chk("tie2_host_wdata", ram_wdata, 32'h88776655);
        tick();
        chk("tie2_no_rvalid", cpu_rvalid, 0);
        chk("tie2_cpu_gnt_late", cpu_gnt, 1);
        chk("tie2_cpu_addr", ram_addr, 9);
        tick();
        cpu_req = 1'b0;
        chk("tie2_rvalid", cpu_rvalid, 1);
        chk("tie2_rdata", cpu_rdata, 32'h01020304);
        chk("tie2_busy", host_busy, 0);
        host_read_chk(5'd11, 32'h88776655);

        // 5: reset after two host bytes aborts the write
        cpu_op(1'b1, 5'd5, 32'hCAFEF00D, 32'h0);
        w0 = we_cnt;
        host_cmd(1'b1, 5'd5);
        send_byte(8'h99); send_byte(8'h98);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", host_busy, 0);
        chk("abort_ram_we", ram_we, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_write", we_cnt, w0);
        host_read_chk(5'd5, 32'hCAFEF00D);

        // 6: stray bytes while idle and a command while busy are ignored
        w0 = we_cnt;
        send_byte(8'hEE); send_byte(8'hFF);
        chk("idle_byte_busy", host_busy, 0);
        chk("idle_byte_no_we", we_cnt, w0);
        host_cmd(1'b1, 5'd12);
        send_byte(8'h01);
        host_cmd_valid = 1'b1; host_cmd_wr = 1'b0; host_addr = 5'd13;
        tick();
        host_cmd_valid = 1'b0;
        chk("busy_cmd_busy", host_busy, 1);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("busy_cmd_we", ram_we, 1);
        chk("busy_cmd_addr", ram_addr, 12);
        chk("busy_cmd_wdata", ram_wdata, 32'h04030201);
        tick();
        chk("busy_cmd_we_count", we_cnt, w0 + 1);
        host_read_chk(5'd12, 32'h04030201);
        cpu_op(1'b0, 5'd13, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
